aes_statemt_buffer: RTL and testbench
=====================================

Name: aes_statemt_buffer

Overview:
- Shared state buffer and sequencer wrapped around aes_decrypt_call.
- Accepts a 16-word ciphertext state from an upstream word stream and writes it into a local 32x32 RAM.
- Pulses the core's ap_start, serves the core's statemt1 single-port memory interface while the core runs, then streams the 16 decrypted words out downstream.
- Owns the RAM; the core is the only other master, and only while it runs.

Parameters:
- DW, 32, data width of stream words and RAM words
- AW, 5, RAM address width (depth 2**AW = 32, matches statemt1_address0)
- NWORDS, 16, words loaded and unloaded per block (addresses 0..NWORDS-1)
- CW, 16, width of completed-block counter

Ports:
- ap_clk  in  1  clock, all logic rising-edge
- ap_rst  in  1  synchronous active-high reset
- in_data  in  DW  upstream state word
- in_valid  in  1  upstream word valid
- in_ready  out  1  block accepts in_data
- out_data  out  DW  downstream decrypted word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- core_start  out  1  to core ap_start
- core_done  in  1  from core ap_done
- core_ready  in  1  from core ap_ready
- core_idle  in  1  from core ap_idle (status only)
- statemt1_address0  in  AW  core memory address
- statemt1_ce0  in  1  core memory enable
- statemt1_we0  in  1  core write enable
- statemt1_d0  in  DW  core write data
- statemt1_q0  out  DW  core read data, registered
- busy  out  1  high in any state except LOAD with zero words accepted
- blocks_done  out  CW  count of fully unloaded blocks

Behaviour:
- Interface: one clock, ap_clk. Reset ap_rst is synchronous and active-high.
- Reset values:
  - in_ready=1 (state LOAD, wr_idx=0); out_valid=0; out_data=0; core_start=0; statemt1_q0=0; busy=0; blocks_done=0.
  - RAM contents are not reset.
- FSM states: LOAD -> START -> RUN -> UNLOAD -> LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, RAM[wr_idx]<=in_data and wr_idx++.
  - The transfer with wr_idx==NWORDS-1 moves the FSM to START next cycle and resets wr_idx to 0.
  - No backpressure inside LOAD; in_ready=0 in all other states.
- START:
  - core_start=1, held until the cycle core_ready=1 is sampled.
  - Next state is RUN, with core_start=0 from that edge.
  - If core_done and core_ready are both high in the same cycle, go directly to UNLOAD.
- RUN:
  - Wait for core_done=1, then go to UNLOAD.
- Core memory port, serviced only in START and RUN:
  - ce0&&we0: RAM[address0]<=d0.
  - ce0&&!we0: statemt1_q0<=RAM[address0], 1-cycle latency.
  - Read and write to the same address in consecutive cycles returns the new data (write completes before the next read).
  - statemt1_q0 holds its value when ce0=0.
  - In LOAD/UNLOAD, core accesses are ignored (no RAM write; q0 holds).
- UNLOAD:
  - Reads RAM[0..NWORDS-1] in order; RAM read latency is 1.
  - out_valid rises 1 cycle after entering UNLOAD.
  - Under continuous out_ready, one word per cycle.
  - While out_valid&&!out_ready, out_data and out_valid stay stable.
  - The handshake on word NWORDS-1: out_valid=0 next cycle, blocks_done++ (wraps at 2**CW), return to LOAD.
- Addresses NWORDS..31: core scratch; never loaded or unloaded.
- core_done or core_ready outside START/RUN is ignored.
- Reset mid-operation (any state): all outputs return to reset values next edge. A core already running is not aborted; it is the integrator's job to reset both together.

Test Plan:
- Basic: stream words 0x00000000..0x0000000F with in_valid=1 continuous; model core swaps nothing, asserts ready 2 cycles after start and done 10 cycles later -> core_start high exactly until the ready edge; out stream 0x0..0xF, 16 consecutive out_valid cycles; blocks_done=1.
- Core read/write: in RUN, core writes 0xDEADBEEF to addr 3, then reads addr 3 and addr 20 -> q0=0xDEADBEEF one cycle after the read; out word 3 = 0xDEADBEEF.
- Backpressure: out_ready toggles 1,0,0,1,... -> no word lost or duplicated, out_data stable during stalls, order 0..15.
- Upstream gaps: in_valid random 50% -> exactly 16 words written, START entered only after the 16th; in_ready=0 after it until blocks_done increments.
- Same-cycle done/ready: core asserts ready and done together -> RUN skipped, UNLOAD entered next cycle, core_start low.
- Reset mid-UNLOAD after 5 words -> next cycle out_valid=0, in_ready=1, blocks_done unchanged (reset value 0), core_start=0; a fresh block then completes normally.

Source files
------------

// File: rtl/aes_statemt_buffer.sv
// aes_statemt_buffer: state RAM and load/start/run/unload sequencer around aes_decrypt_call
module aes_statemt_buffer #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NWORDS = 16,
  parameter int CW = 16
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          core_start,
  input  logic          core_done,
  input  logic          core_ready,
  input  logic          core_idle,
  input  logic [AW-1:0] statemt1_address0,
  input  logic          statemt1_ce0,
  input  logic          statemt1_we0,
  input  logic [DW-1:0] statemt1_d0,
  output logic [DW-1:0] statemt1_q0,
  output logic          busy,
  output logic [CW-1:0] blocks_done
);
  localparam logic [1:0] LOAD = 2'd0, START = 2'd1, RUN = 2'd2, UNLOAD = 2'd3;
  localparam logic [AW-1:0] LAST = AW'(NWORDS - 1);
  localparam logic [AW:0] ALL = (AW + 1)'(NWORDS);
  logic [DW-1:0] ram [2**AW];
  logic [1:0] state;
  logic [AW-1:0] wr_idx;
  logic [AW:0] rd_idx;
  logic in_fire, core_en, unused_idle;
  assign unused_idle = core_idle;
  assign in_ready = state == LOAD;
  assign core_start = state == START;
  assign busy = state != LOAD || wr_idx != '0;
  assign in_fire = in_ready && in_valid;
  assign core_en = (state == START || state == RUN) && statemt1_ce0;
  // RAM writes: upstream owns the port in LOAD, the core in START/RUN
  always_ff @(posedge ap_clk) begin
    if (in_fire) ram[wr_idx] <= in_data;
    else if (core_en && statemt1_we0) ram[statemt1_address0] <= statemt1_d0;
  end
  // core read data register, holds when the core is not reading
  always_ff @(posedge ap_clk) begin
    if (ap_rst) statemt1_q0 <= '0;
    else if (core_en && !statemt1_we0) statemt1_q0 <= ram[statemt1_address0];
  end
  // sequencer, load index, unload pipeline and block counter
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= LOAD;
      wr_idx <= '0;
      rd_idx <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      blocks_done <= '0;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          wr_idx <= wr_idx == LAST ? '0 : wr_idx + 1'b1;
          if (wr_idx == LAST) state <= START;
        end
        START: if (core_ready) state <= core_done ? UNLOAD : RUN;
        RUN: if (core_done) state <= UNLOAD;
        default: if (!out_valid || out_ready) begin
          if (rd_idx == ALL) begin
            out_valid <= 1'b0;
            rd_idx <= '0;
            blocks_done <= blocks_done + 1'b1;
            state <= LOAD;
          end else begin
            out_data <= ram[rd_idx[AW-1:0]];
            out_valid <= 1'b1;
            rd_idx <= rd_idx + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_statemt_buffer.sv
// tb_aes_statemt_buffer: directed scoreboard bench for aes_statemt_buffer
module tb_aes_statemt_buffer;
  logic ap_clk = 0, ap_rst = 1;
  logic [31:0] in_data = 0, out_data, statemt1_d0 = 0, statemt1_q0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic core_start, core_done = 0, core_ready = 0, core_idle = 1;
  logic [4:0] statemt1_address0 = 0;
  logic statemt1_ce0 = 0, statemt1_we0 = 0, busy;
  logic [15:0] blocks_done, exp_blocks = 0;
  int vectors = 0, miscompares = 0, cycles, hs;
  logic [31:0] expq [$];
  logic [31:0] words [16];
  logic [31:0] expw [16];
  logic stall = 0;
  logic [31:0] held = 0;

  aes_statemt_buffer dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .core_start(core_start),
    .core_done(core_done), .core_ready(core_ready), .core_idle(core_idle),
    .statemt1_address0(statemt1_address0), .statemt1_ce0(statemt1_ce0), .statemt1_we0(statemt1_we0),
    .statemt1_d0(statemt1_d0), .statemt1_q0(statemt1_q0), .busy(busy), .blocks_done(blocks_done)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // monitor: pops the scoreboard on each output handshake and checks stall stability
  always @(negedge ap_clk) begin
    if (ap_rst) stall <= 0;
    else begin
      if (stall) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data", out_data, held);
      end
      stall <= out_valid && !out_ready;
      held <= out_data;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_word: got %h expected no word", out_data);
        end else chk("out_word", out_data, expq.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_load(input bit gaps);
    for (int i = 0; i < 16; i++) expq.push_back(expw[i]);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        int ng = (i % 4 == 0) ? 1 : $urandom_range(0, 2);
        for (int g = 0; g < ng; g++) begin
          in_valid = 0;
          statemt1_ce0 = 1; statemt1_we0 = 0; statemt1_address0 = 3;
          core_ready = 1; core_done = 1;
          tick;
          core_ready = 0; core_done = 0;
        end
        statemt1_ce0 = 1; statemt1_we0 = 1; statemt1_address0 = 5; statemt1_d0 = 32'h00000BAD;
      end
      chk("load_in_ready", 32'(in_ready), 1);
      chk("load_no_start", 32'(core_start), 0);
      if (i == 1) chk("load_busy", 32'(busy), 1);
      in_valid = 1;
      in_data = words[i];
      tick;
    end
    in_valid = 0; statemt1_ce0 = 0; statemt1_we0 = 0;
    chk("start_after_16", 32'(core_start), 1);
    chk("start_in_ready", 32'(in_ready), 0);
    chk("start_busy", 32'(busy), 1);
  endtask

  task automatic mem_ops;
    statemt1_ce0 = 1; statemt1_we0 = 1; statemt1_address0 = 20; statemt1_d0 = 32'h12345678;
    tick;
    statemt1_address0 = 3; statemt1_d0 = 32'hDEADBEEF;
    tick;
    statemt1_we0 = 0;
    tick;
    chk("q0_addr3", statemt1_q0, 32'hDEADBEEF);
    statemt1_address0 = 20;
    tick;
    chk("q0_addr20", statemt1_q0, 32'h12345678);
    statemt1_ce0 = 0;
    tick;
    chk("q0_hold", statemt1_q0, 32'h12345678);
  endtask

  task automatic run_core(input int rdly, input int ddly, input bit same, input bit mem);
    for (int k = 0; k < rdly; k++) begin
      chk("start_held", 32'(core_start), 1);
      tick;
    end
    core_ready = 1;
    core_done = same;
    chk("start_at_ready", 32'(core_start), 1);
    tick;
    core_ready = 0; core_done = 0;
    chk("start_dropped", 32'(core_start), 0);
    if (!same) begin
      if (mem) mem_ops;
      for (int k = 0; k < ddly; k++) begin
        chk("run_in_ready", 32'(in_ready), 0);
        tick;
      end
      core_done = 1;
      tick;
      core_done = 0;
    end
    chk("unload_entry_valid", 32'(out_valid), 0);
  endtask

  task automatic unload(input bit toggle);
    cycles = 0;
    exp_blocks++;
    while (blocks_done != exp_blocks && cycles < 200) begin
      out_ready = toggle ? (cycles % 3 == 0) : 1'b1;
      tick;
      cycles++;
    end
    out_ready = 0;
    chk("blocks_done", 32'(blocks_done), 32'(exp_blocks));
    chk("end_valid", 32'(out_valid), 0);
    chk("end_in_ready", 32'(in_ready), 1);
    chk("end_busy", 32'(busy), 0);
    chk("drained", 32'(expq.size()), 0);
  endtask

  initial begin
    tick; tick;
    ap_rst = 0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_core_start", 32'(core_start), 0);
    chk("rst_q0", statemt1_q0, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_blocks", 32'(blocks_done), 0);
    // basic block
    for (int i = 0; i < 16; i++) begin words[i] = 32'(i); expw[i] = 32'(i); end
    do_load(0);
    run_core(2, 10, 0, 0);
    unload(0);
    chk("basic_cycles", 32'(cycles), 17);
    // core read/write in RUN
    for (int i = 0; i < 16; i++) begin words[i] = 32'h100 + 32'(i); expw[i] = words[i]; end
    expw[3] = 32'hDEADBEEF;
    do_load(0);
    run_core(1, 4, 0, 1);
    unload(0);
    // downstream backpressure 1,0,0 repeating
    for (int i = 0; i < 16; i++) begin words[i] = 32'hA0000000 + 32'(i); expw[i] = words[i]; end
    do_load(0);
    run_core(2, 3, 0, 0);
    unload(1);
    // upstream gaps with core noise during LOAD
    for (int i = 0; i < 16; i++) begin words[i] = 32'h5000 + 32'(i * 3); expw[i] = words[i]; end
    do_load(1);
    chk("q0_ignored_in_load", statemt1_q0, 32'h12345678);
    run_core(2, 2, 0, 0);
    unload(0);
    // done and ready in the same cycle
    for (int i = 0; i < 16; i++) begin words[i] = ~32'(i); expw[i] = words[i]; end
    do_load(0);
    run_core(3, 0, 1, 0);
    unload(0);
    chk("same_cycles", 32'(cycles), 17);
    // reset after 5 unloaded words
    for (int i = 0; i < 16; i++) begin words[i] = 32'h99000000 + 32'(i); expw[i] = words[i]; end
    do_load(0);
    run_core(2, 3, 0, 0);
    out_ready = 1;
    hs = 0;
    for (int g = 0; g < 100 && hs < 5; g++) begin
      if (out_valid) hs++;
      tick;
    end
    out_ready = 0;
    ap_rst = 1;
    tick;
    ap_rst = 0;
    expq.delete();
    exp_blocks = 0;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_blocks", 32'(blocks_done), 0);
    chk("mid_rst_start", 32'(core_start), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_q0", statemt1_q0, 0);
    // fresh block after reset
    for (int i = 0; i < 16; i++) begin words[i] = 32'h77000000 + 32'(i); expw[i] = words[i]; end
    do_load(0);
    run_core(2, 10, 0, 0);
    unload(0);
    chk("fresh_cycles", 32'(cycles), 17);
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
